fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//   Parametrised single-clock BRAM FIFO; successor to the fixed 8-bit FIFO_BRAM_SYNC.
//   Buffers sniffer bytes/words between the USB3300 capture logic and the UART/host
//   readout path. Adds width/depth generics, occupancy count, sticky error flags,
//   synchronous flush and a compile-time first-word-fall-through (FWFT) read mode.
// PARAMETERS
//   DATA_WIDTH        8   word width in bits (1..32)
//   ADDR_WIDTH        9   log2 of depth; DEPTH = 2**ADDR_WIDTH words (capacity = DEPTH)
//   ALMOST_FULL_VAL   8   wr_almost_full asserted when level >= this value
//   ALMOST_EMPTY_VAL  2   rd_almost_empty asserted when level <= this value
// PORTS
//   clk              in   1             single clock, all logic on rising edge
//   rst              in   1             asynchronous reset, active-low
//   flush            in   1             sync clear of contents and flags
//   wr_dv            in   1             write request
//   wr_DATA          in   DATA_WIDTH    write data
//   wr_full          out  1             level == DEPTH
//   wr_almost_full   out  1             level >= ALMOST_FULL_VAL
//   rd_en            in   1             read request / FWFT pop
//   rd_DATA          out  DATA_WIDTH    read data (registered)
//   rd_empty         out  1             no word available to read
//   rd_almost_empty  out  1             level <= ALMOST_EMPTY_VAL
//   level            out  ADDR_WIDTH+1  words accepted and not yet consumed (0..DEPTH)
//   overflow         out  1             sticky: wr_dv seen while wr_full
//   underflow        out  1             sticky: rd_en seen while rd_empty
// BEHAVIOUR
//   - Reset (rst=0, async): pointers=0, level=0, rd_DATA=0, rd_empty=1,
//     rd_almost_empty=1, wr_full=0, wr_almost_full=0, overflow=0, underflow=0.
//     Reset mid-transfer discards all contents; no partial word survives.
//   - Write accepted iff wr_dv & ~wr_full: mem[wr_ptr]<=wr_DATA, wr_ptr++ (mod DEPTH).
//   - Read accepted iff rd_en & ~rd_empty: rd_ptr++ (mod DEPTH).
//   - Pointers are ADDR_WIDTH+1 bits; wrap from DEPTH-1 to 0 is transparent.
//   - level: +1 write only, -1 read only, unchanged on simultaneous accepted rd+wr
//     or neither. All flags are registered and derive from next-state level.
//   - Full + wr_dv + rd_en: read accepted, write rejected, overflow set.
//   - Empty + wr_dv + rd_en: write accepted, read rejected, underflow set.
//   - Rejected requests never alter pointers, memory or rd_DATA.
//   - flush=1: pointers, level, overflow, underflow cleared next edge; flags go to
//     reset values; rd_DATA holds. flush has priority over wr_dv/rd_en that cycle.
//   - Sticky flags cleared only by rst or flush.
//   - Standard mode: rd_DATA updated one clock after the accepted rd_en edge and
//     holds its value until the next accepted read.
// CONFIGURATION
//   FIFO_FWFT_EN undefined: standard mode as above, rd_empty = (level == 0).
//   FIFO_FWFT_EN defined: one-word output register pre-fetches the head word;
//     rd_DATA is valid whenever rd_empty=0; rd_en acts as pop/ack. A write to an
//     empty FIFO at edge N gives rd_empty=0 with data on rd_DATA after edge N+1.
//     Pop with further words stored reloads rd_DATA at the same edge (back-to-back
//     pops at full rate). Output register counts in level; capacity stays DEPTH.
//     flush/rst also invalidate the output register.
// TESTING
//   1 rst low 2 cycles -> all outputs at reset values; level=0, rd_empty=1.
//   2 write 8'h18,29,3A,4B,5C,6D,7E,BF then 8 reads -> same order on rd_DATA,
//     level 8->0, almost_full at level 8, almost_empty at level <= 2.
//   3 fill to DEPTH, 1 extra wr_dv -> wr_full=1, overflow=1, level=DEPTH; drain
//     all -> data intact across pointer wrap, rd_empty=1.
//   4 at level 3: wr_dv+rd_en together 5 cycles -> level stays 3, FIFO order kept;
//     at level 0 same -> level 1, underflow=1.
//   5 level 5, flush=1 with wr_dv=1 -> level 0, rd_empty=1, flags clear, no write.
//   6 FIFO_FWFT_EN: write 8'h58 to empty -> rd_DATA=8'h58, rd_empty=0 one edge
//     later, before any rd_en; rd_en pop -> rd_empty=1, level 0.

Source files
------------

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
//   Parametrised single-clock block-RAM FIFO that buffers sniffer bytes/words
//   between the USB3300 capture logic and the UART/host readout path. It
//   provides an occupancy count, sticky overflow/underflow flags, a synchronous
//   flush and an optional first-word-fall-through (FWFT) read mode.
//
//   Compile-time option:
//     FIFO_FWFT_EN  undefined : standard mode. rd_DATA is loaded one clock after
//                               an accepted rd_en and holds until the next
//                               accepted read. rd_empty = (level == 0).
//     FIFO_FWFT_EN  defined   : a one-word output register pre-fetches the head
//                               word. rd_DATA is valid whenever rd_empty = 0, and
//                               rd_en pops it. The output register counts in
//                               level. Capacity stays DEPTH.
//
// Parameters
//   DATA_WIDTH        word width in bits (1..32)
//   ADDR_WIDTH        log2 of depth, DEPTH = 2**ADDR_WIDTH words
//   ALMOST_FULL_VAL   wr_almost_full when level >= this value
//   ALMOST_EMPTY_VAL  rd_almost_empty when level <= this value
//
// Ports
//   clk              in   single clock, rising edge
//   rst              in   asynchronous reset, active-low
//   flush            in   synchronous clear of contents and flags (wins over wr/rd)
//   wr_dv            in   write request
//   wr_DATA          in   write data
//   wr_full          out  level == DEPTH
//   wr_almost_full   out  level >= ALMOST_FULL_VAL
//   rd_en            in   read request / FWFT pop
//   rd_DATA          out  registered read data
//   rd_empty         out  no word available to read
//   rd_almost_empty  out  level <= ALMOST_EMPTY_VAL
//   level            out  words accepted and not yet consumed (0..DEPTH)
//   overflow         out  sticky: wr_dv seen while wr_full
//   underflow        out  sticky: rd_en seen while rd_empty
//
// Handshake: a write is accepted on a rising edge when wr_dv=1 and wr_full=0.
// A read is accepted when rd_en=1 and rd_empty=0. A request that is not
// accepted has no effect except for setting the matching sticky error flag.
// During flush, no request is accepted.
// -----------------------------------------------------------------------------
module fifo_sync_param #(
   parameter int DATA_WIDTH       = 8,
   parameter int ADDR_WIDTH       = 9,
   parameter int ALMOST_FULL_VAL  = 8,
   parameter int ALMOST_EMPTY_VAL = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_dv,
   input  logic [DATA_WIDTH-1:0] wr_DATA,
   output logic                  wr_full,
   output logic                  wr_almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_DATA,
   output logic                  rd_empty,
   output logic                  rd_almost_empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE_L   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] ZERO_L  = '0;
   localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(ALMOST_FULL_VAL);
   localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_VAL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Pointers carry one extra bit so that a full memory is distinguishable
   // from an empty one; the low ADDR_WIDTH bits address the RAM.
   logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]   wr_ptr_nxt, rd_ptr_nxt, level_nxt;
   logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic                  wr_acc, rd_acc;
   logic                  mem_rd;      // RAM word moves into rd_DATA this edge
   logic                  empty_nxt;

   assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
   assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

   assign wr_acc = wr_dv & ~wr_full & ~flush;
   assign rd_acc = rd_en & ~rd_empty & ~flush;

`ifdef FIFO_FWFT_EN
   // The output register is refilled whenever the RAM holds a word and the
   // register is either empty or being popped this edge, so back-to-back pops
   // run at full rate. A word written at edge N is seen by the pointer compare
   // after edge N and lands in rd_DATA at edge N+1.
   assign mem_rd    = (wr_ptr != rd_ptr) & (rd_empty | rd_acc) & ~flush;
   assign empty_nxt = ~mem_rd & (rd_empty | rd_acc);
`else
   assign mem_rd    = rd_acc;
   assign empty_nxt = (level_nxt == ZERO_L);
`endif

   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      if (wr_acc) wr_ptr_nxt = wr_ptr + ONE_L;
      if (mem_rd) rd_ptr_nxt = rd_ptr + ONE_L;
`ifdef FIFO_FWFT_EN
      // Words in RAM plus the word parked in the output register.
      level_nxt = wr_ptr_nxt - rd_ptr_nxt + {{ADDR_WIDTH{1'b0}}, ~empty_nxt};
`else
      level_nxt = wr_ptr_nxt - rd_ptr_nxt;
`endif
   end

   // RAM array: no reset so it maps onto block RAM. Contents become
   // unreachable after rst/flush because both pointers return to zero.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_addr] <= wr_DATA;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         level           <= '0;
         rd_DATA         <= '0;
         rd_empty        <= 1'b1;
         rd_almost_empty <= 1'b1;
         wr_full         <= 1'b0;
         wr_almost_full  <= 1'b0;
         overflow        <= 1'b0;
         underflow       <= 1'b0;
      end else if (flush) begin
         // rd_DATA deliberately keeps its last value.
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         level           <= '0;
         rd_empty        <= 1'b1;
         rd_almost_empty <= 1'b1;
         wr_full         <= 1'b0;
         wr_almost_full  <= 1'b0;
         overflow        <= 1'b0;
         underflow       <= 1'b0;
      end else begin
         wr_ptr          <= wr_ptr_nxt;
         rd_ptr          <= rd_ptr_nxt;
         if (mem_rd) rd_DATA <= mem[rd_addr];
         level           <= level_nxt;
         rd_empty        <= empty_nxt;
         rd_almost_empty <= (level_nxt <= AE_L);
         wr_full         <= (level_nxt == DEPTH_L);
         wr_almost_full  <= (level_nxt >= AF_L);
         if (wr_dv & wr_full)  overflow  <= 1'b1;
         if (rd_en & rd_empty) underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
//   Self-checking bench for fifo_sync_param with default parameters
//   (8-bit words, 512 deep, almost_full at 8, almost_empty at 2).
//   Standard build: table-driven ordering test plus scoreboarded corner-case
//   sequences and a random phase. FIFO_FWFT_EN build: hand-written FWFT
//   sequences.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

   localparam int DEPTH = 512;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       wr_dv;
   logic [7:0] wr_data;
   logic       wr_full;
   logic       wr_almost_full;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_empty;
   logic       rd_almost_empty;
   logic [9:0] level;
   logic       overflow;
   logic       underflow;

   fifo_sync_param dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .wr_dv           (wr_dv),
      .wr_DATA         (wr_data),
      .wr_full         (wr_full),
      .wr_almost_full  (wr_almost_full),
      .rd_en           (rd_en),
      .rd_DATA         (rd_data),
      .rd_empty        (rd_empty),
      .rd_almost_empty (rd_almost_empty),
      .level           (level),
      .overflow        (overflow),
      .underflow       (underflow)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // scoreboard state
   logic [7:0] exp_q[$];
   logic [7:0] m_last = 8'h00;
   logic       m_ovf  = 1'b0;
   logic       m_unf  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic f, input logic w, input logic r, input logic [7:0] d);
      flush = f;
      wr_dv = w;
      rd_en = r;
      wr_data = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_level"}, int'(level), 0);
      chk({tag, "_rd_empty"}, int'(rd_empty), 1);
      chk({tag, "_rd_aempty"}, int'(rd_almost_empty), 1);
      chk({tag, "_wr_full"}, int'(wr_full), 0);
      chk({tag, "_wr_afull"}, int'(wr_almost_full), 0);
      chk({tag, "_overflow"}, int'(overflow), 0);
      chk({tag, "_underflow"}, int'(underflow), 0);
      chk({tag, "_rd_data"}, int'(rd_data), 0);
   endtask

`ifndef FIFO_FWFT_EN
   task automatic check_outputs();
      int sz;
      sz = exp_q.size();
      chk("level", int'(level), sz);
      chk("rd_empty", int'(rd_empty), int'(sz == 0));
      chk("wr_full", int'(wr_full), int'(sz == DEPTH));
      chk("wr_almost_full", int'(wr_almost_full), int'(sz >= 8));
      chk("rd_almost_empty", int'(rd_almost_empty), int'(sz <= 2));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_unf));
      chk("rd_data", int'(rd_data), int'(m_last));
   endtask

   // One clock of stimulus with the reference model updated from the
   // pre-edge model state, then every output compared after the edge.
   task automatic cycle(input logic f, input logic w, input logic r, input logic [7:0] d);
      logic w_acc, r_acc;
      int   sz;
      drive(f, w, r, d);
      sz = exp_q.size();
      w_acc = w && !f && (sz < DEPTH);
      r_acc = r && !f && (sz > 0);
      if (f) begin
         exp_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (w && sz == DEPTH) m_ovf = 1'b1;
         if (r && sz == 0)     m_unf = 1'b1;
         if (r_acc) m_last = exp_q.pop_front();
         if (w_acc) exp_q.push_back(d);
      end
      tick();
      check_outputs();
   endtask

   typedef struct {
      logic       wr;
      logic       rd;
      logic [7:0] din;
      logic [9:0] e_level;
      logic       e_af;
      logic       e_ae;
      logic       e_chk;
      logic [7:0] e_data;
   } vec_t;
   vec_t vecs[16];
`endif

   initial begin
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 8'h00);

      // reset held for two cycles
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1'b1;
      tick();

`ifndef FIFO_FWFT_EN
      // ordering and threshold flags, table-driven
      vecs[0]  = '{1'b1, 1'b0, 8'h18, 10'd1, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[1]  = '{1'b1, 1'b0, 8'h29, 10'd2, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[2]  = '{1'b1, 1'b0, 8'h3A, 10'd3, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[3]  = '{1'b1, 1'b0, 8'h4B, 10'd4, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[4]  = '{1'b1, 1'b0, 8'h5C, 10'd5, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[5]  = '{1'b1, 1'b0, 8'h6D, 10'd6, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[6]  = '{1'b1, 1'b0, 8'h7E, 10'd7, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[7]  = '{1'b1, 1'b0, 8'hBF, 10'd8, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[8]  = '{1'b0, 1'b1, 8'h00, 10'd7, 1'b0, 1'b0, 1'b1, 8'h18};
      vecs[9]  = '{1'b0, 1'b1, 8'h00, 10'd6, 1'b0, 1'b0, 1'b1, 8'h29};
      vecs[10] = '{1'b0, 1'b1, 8'h00, 10'd5, 1'b0, 1'b0, 1'b1, 8'h3A};
      vecs[11] = '{1'b0, 1'b1, 8'h00, 10'd4, 1'b0, 1'b0, 1'b1, 8'h4B};
      vecs[12] = '{1'b0, 1'b1, 8'h00, 10'd3, 1'b0, 1'b0, 1'b1, 8'h5C};
      vecs[13] = '{1'b0, 1'b1, 8'h00, 10'd2, 1'b0, 1'b1, 1'b1, 8'h6D};
      vecs[14] = '{1'b0, 1'b1, 8'h00, 10'd1, 1'b0, 1'b1, 1'b1, 8'h7E};
      vecs[15] = '{1'b0, 1'b1, 8'h00, 10'd0, 1'b0, 1'b1, 1'b1, 8'hBF};
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].din);
         chk($sformatf("vec%0d_level", i), int'(level), int'(vecs[i].e_level));
         chk($sformatf("vec%0d_afull", i), int'(wr_almost_full), int'(vecs[i].e_af));
         chk($sformatf("vec%0d_aempty", i), int'(rd_almost_empty), int'(vecs[i].e_ae));
         if (vecs[i].e_chk)
            chk($sformatf("vec%0d_data", i), int'(rd_data), int'(vecs[i].e_data));
      end

      // fill to capacity across the pointer wrap, one extra write, drain
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
      cycle(1'b0, 1'b1, 1'b0, 8'hEE);
      chk("full_flag", int'(wr_full), 1);
      chk("full_overflow", int'(overflow), 1);
      chk("full_level", int'(level), DEPTH);
      // full with both requests: read accepted, write rejected
      cycle(1'b0, 1'b1, 1'b1, 8'hDD);
      chk("full_rw_level", int'(level), DEPTH - 1);
      for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
      chk("drain_empty", int'(rd_empty), 1);

      // simultaneous read and write at level 3, then at level 0
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 1'b1, 8'(8'hD0 + i));
         chk("rw3_level", int'(level), 3);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 1'b1, 8'h77);
      chk("rw0_level", int'(level), 1);
      chk("rw0_underflow", int'(underflow), 1);

      // flush at level 5 with a concurrent write
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'hE0 + i));
      chk("pre_flush_level", int'(level), 5);
      cycle(1'b1, 1'b1, 1'b0, 8'hFF);
      chk("flush_level", int'(level), 0);
      chk("flush_empty", int'(rd_empty), 1);
      chk("flush_ovf", int'(overflow), 0);
      chk("flush_unf", int'(underflow), 0);
      cycle(1'b0, 1'b1, 1'b0, 8'h11);
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      chk("post_flush_data", int'(rd_data), 8'h11);

      // asynchronous reset in the middle of a transfer
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
      drive(1'b0, 1'b1, 1'b0, 8'h55);
      rst = 1'b0;
      #2;
      chk("async_rst_level", int'(level), 0);
      chk("async_rst_empty", int'(rd_empty), 1);
      exp_q.delete();
      m_last = 8'h00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      tick();
      rst = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 8'h3C);
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      chk("post_rst_data", int'(rd_data), 8'h3C);

      // random traffic against the scoreboard
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 63) == 0),
               1'($urandom_range(0, 99) < 55),
               1'($urandom_range(0, 99) < 50),
               8'($urandom_range(0, 255)));
      end
`else
      // FWFT: write to empty, data visible one edge later without rd_en
      drive(1'b0, 1'b1, 1'b0, 8'h58);
      tick();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      chk("fwft_n_level", int'(level), 1);
      chk("fwft_n_empty", int'(rd_empty), 1);
      tick();
      chk("fwft_n1_empty", int'(rd_empty), 0);
      chk("fwft_n1_data", int'(rd_data), 8'h58);
      chk("fwft_n1_level", int'(level), 1);
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      tick();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      chk("fwft_pop_empty", int'(rd_empty), 1);
      chk("fwft_pop_level", int'(level), 0);
      chk("fwft_pop_unf", int'(underflow), 0);

      // back-to-back pops reload the output register at the same edge
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0, 8'(8'hA1 + i));
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      tick();
      chk("fwft_b2b_level", int'(level), 3);
      chk("fwft_b2b_head", int'(rd_data), 8'hA1);
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      tick();
      chk("fwft_b2b_d2", int'(rd_data), 8'hA2);
      chk("fwft_b2b_l2", int'(level), 2);
      chk("fwft_b2b_e2", int'(rd_empty), 0);
      tick();
      chk("fwft_b2b_d3", int'(rd_data), 8'hA3);
      chk("fwft_b2b_l1", int'(level), 1);
      tick();
      chk("fwft_b2b_empty", int'(rd_empty), 1);
      chk("fwft_b2b_l0", int'(level), 0);
      tick();
      chk("fwft_unf", int'(underflow), 1);

      // flush invalidates the output register but leaves rd_DATA alone
      drive(1'b0, 1'b1, 1'b0, 8'hB5);
      tick();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      chk("fwft_pre_flush", int'(rd_data), 8'hB5);
      drive(1'b1, 1'b1, 1'b0, 8'hC6);
      tick();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      chk("fwft_flush_empty", int'(rd_empty), 1);
      chk("fwft_flush_level", int'(level), 0);
      chk("fwft_flush_unf", int'(underflow), 0);
      chk("fwft_flush_hold", int'(rd_data), 8'hB5);
      tick();
      tick();
      chk("fwft_flush_nowrite", int'(rd_empty), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
